// File: rtl/matrix_mem_loader_if.sv
// Stream-in / RAM-write bundle for matrix_mem_loader; slave is the loader, master the producer.
// LOADER_CHECKSUM_EN adds checksum_o to the bundle.
interface matrix_mem_loader_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   length;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;
    logic              mem_we_o;
    logic              busy_o;
    logic              is_done_o;
    logic [ADDR_W:0]   count_o;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_o;

    modport slave (
        input  start, base_addr, length, in_valid, in_data,
        output in_ready, mem_addr_o, mem_data_o, mem_we_o, busy_o, is_done_o, count_o, checksum_o
    );
    modport master (
        output start, base_addr, length, in_valid, in_data,
        input  in_ready, mem_addr_o, mem_data_o, mem_we_o, busy_o, is_done_o, count_o, checksum_o
    );
`else
    modport slave (
        input  start, base_addr, length, in_valid, in_data,
        output in_ready, mem_addr_o, mem_data_o, mem_we_o, busy_o, is_done_o, count_o
    );
    modport master (
        output start, base_addr, length, in_valid, in_data,
        input  in_ready, mem_addr_o, mem_data_o, mem_we_o, busy_o, is_done_o, count_o
    );
`endif
endinterface

// File: rtl/matrix_mem_loader.sv
// Loads a valid/ready word stream into a single-port RAM from base_addr for length words.
// Write latency 1 cycle; in_ready only in LOAD. LOADER_CHECKSUM_EN adds a running checksum.
module matrix_mem_loader #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    matrix_mem_loader_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_data;
    logic              r_mem_we;
    logic              w_start;
    logic              w_xfer;
    logic [ADDR_W:0]   w_cnt_nxt;

    // start is ignored while a load is in flight
    assign w_start   = bus.start && (r_state != S_LOAD);
    assign w_xfer    = bus.in_valid && (r_state == S_LOAD);
    assign w_cnt_nxt = r_count + {{ADDR_W{1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_state_nxt = (bus.length == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_xfer && (w_cnt_nxt == r_len)) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (r_state == S_LOAD);
        bus.busy_o    = (r_state == S_LOAD);
        bus.is_done_o = (r_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_base     <= '0;
            r_len      <= '0;
            r_count    <= '0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_mem_we   <= 1'b0;
        end else begin
            r_mem_we <= w_xfer;
            if (w_start) begin
                r_base  <= bus.base_addr;
                r_len   <= bus.length;
                r_count <= '0;
            end
            if (w_xfer) begin
                r_mem_addr <= r_base + r_count[ADDR_W-1:0];
                r_mem_data <= bus.in_data;
                r_count    <= w_cnt_nxt;
            end
        end
    end

    assign bus.mem_addr_o = r_mem_addr;
    assign bus.mem_data_o = r_mem_data;
    assign bus.mem_we_o   = r_mem_we;
    assign bus.count_o    = r_count;

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    // sums words as they are accepted so it lands with the matching mem_we_o pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_checksum <= '0;
        end else if (w_start) begin
            r_checksum <= '0;
        end else if (w_xfer) begin
            r_checksum <= r_checksum + bus.in_data;
        end
    end

    assign bus.checksum_o = r_checksum;
`endif
endmodule

// File: tb/tb_matrix_mem_loader.sv
// Scoreboard bench for matrix_mem_loader: expected writes queued as words are driven, popped on mem_we_o.
module tb_matrix_mem_loader;
    typedef struct packed {
        logic [5:0] a;
        logic [7:0] d;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    int         n_vec = 0;
    int         n_err = 0;
    int         n_wr = 0;
    wr_t        exp_q[$];
    logic [7:0] d_q[$];
    logic [7:0] ram [64];
    logic [5:0] last_a = '0;
    logic [7:0] last_d = '0;

    matrix_mem_loader_if #(.ADDR_W(6), .DATA_W(8)) lb ();

    matrix_mem_loader #(.ADDR_W(6), .DATA_W(8)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (lb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            last_a = '0;
            last_d = '0;
        end else if (lb.mem_we_o) begin
            n_wr++;
            if (exp_q.size() == 0) begin
                chk("spurious_wr", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", {26'd0, lb.mem_addr_o}, {26'd0, e.a});
                chk("wr_data", {24'd0, lb.mem_data_o}, {24'd0, e.d});
            end
            ram[lb.mem_addr_o] = lb.mem_data_o;
            last_a = lb.mem_addr_o;
            last_d = lb.mem_data_o;
        end else begin
            chk("addr_hold", {26'd0, lb.mem_addr_o}, {26'd0, last_a});
            chk("data_hold", {24'd0, lb.mem_data_o}, {24'd0, last_d});
        end
    end

    // mode 0: in_valid held high; mode 1: in_valid pattern 1,0,0 repeating
    task automatic run_load(input logic [5:0] base, input logic [6:0] len, input int mode, input int stop_at);
        int         k;
        int         cyc;
        int         target;
        int         wr0;
        logic       v;
        logic [5:0] a;
        k      = 0;
        cyc    = 0;
        target = (stop_at < int'(len)) ? stop_at : int'(len);
        wr0    = n_wr;
        @(negedge clk);
        lb.start     = 1'b1;
        lb.base_addr = base;
        lb.length    = len;
        @(negedge clk);
        lb.start = 1'b0;
        chk("cnt_clr", {25'd0, lb.count_o}, 32'd0);
        chk("busy_after_start", {31'd0, lb.busy_o}, {31'd0, (len != 0)});
        while (k < target && cyc < 200) begin
            v           = (mode == 0) || (cyc % 3 == 0);
            lb.in_valid = v;
            lb.in_data  = d_q[k];
            if (v && lb.in_ready) begin
                a = base + 6'(k);
                exp_q.push_back('{a: a, d: d_q[k]});
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        lb.in_valid = 1'b0;
        if (k < target) chk("load_timeout", k, target);
        if (mode == 0) chk("consec_cycles", cyc, target);
        if (target == int'(len)) begin
            chk("done_flag", {31'd0, lb.is_done_o}, 32'd1);
            chk("ready_low", {31'd0, lb.in_ready}, 32'd0);
            chk("busy_low", {31'd0, lb.busy_o}, 32'd0);
            chk("cnt_final", {25'd0, lb.count_o}, {25'd0, len});
            lb.in_valid = 1'b1;
            lb.in_data  = 8'hEE;
            repeat (3) @(negedge clk);
            lb.in_valid = 1'b0;
            @(negedge clk);
            chk("wr_total", n_wr - wr0, {25'd0, len});
            chk("q_empty", exp_q.size(), 32'd0);
            chk("cnt_hold", {25'd0, lb.count_o}, {25'd0, len});
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0;
        lb.start     = 1'b0;
        lb.base_addr = '0;
        lb.length    = '0;
        lb.in_valid  = 1'b0;
        lb.in_data   = '0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_we", {31'd0, lb.mem_we_o}, 32'd0);
        chk("rst_cnt", {25'd0, lb.count_o}, 32'd0);
        chk("rst_ready", {31'd0, lb.in_ready}, 32'd0);
        chk("rst_done", {31'd0, lb.is_done_o}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // contiguous burst
        d_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        run_load(6'd0, 7'd8, 0, 99);
        for (int i = 0; i < 8; i++) chk("ram_burst", {24'd0, ram[i]}, i + 1);

        // address wrap
        d_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        run_load(6'd62, 7'd4, 0, 99);
        chk("ram_62", {24'd0, ram[62]}, 32'hA0);
        chk("ram_63", {24'd0, ram[63]}, 32'hA1);
        chk("ram_0", {24'd0, ram[0]}, 32'hA2);
        chk("ram_1", {24'd0, ram[1]}, 32'hA3);

        // gapped stream
        d_q = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
        run_load(6'd20, 7'd5, 1, 99);

        // zero length
        run_load(6'd33, 7'd0, 0, 99);

        // reset mid-load
        d_q = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
        run_load(6'd40, 7'd6, 0, 3);
        lb.in_valid = 1'b1;
        lb.in_data  = 8'h77;
        #2 rst_n = 1'b0;
        #1;
        wr0 = n_wr;
        chk("abort_we", {31'd0, lb.mem_we_o}, 32'd0);
        chk("abort_addr", {26'd0, lb.mem_addr_o}, 32'd0);
        chk("abort_data", {24'd0, lb.mem_data_o}, 32'd0);
        chk("abort_cnt", {25'd0, lb.count_o}, 32'd0);
        chk("abort_busy", {31'd0, lb.busy_o}, 32'd0);
        chk("abort_done", {31'd0, lb.is_done_o}, 32'd0);
        chk("abort_ready", {31'd0, lb.in_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_ready", {31'd0, lb.in_ready}, 32'd0);
        chk("idle_no_wr", n_wr - wr0, 32'd0);
        chk("abort_q_empty", exp_q.size(), 32'd0);
        lb.in_valid = 1'b0;
        d_q = '{8'hC0, 8'hC1};
        run_load(6'd10, 7'd2, 0, 99);
        chk("ram_10", {24'd0, ram[10]}, 32'hC0);
        chk("ram_11", {24'd0, ram[11]}, 32'hC1);

`ifdef LOADER_CHECKSUM_EN
        d_q = '{8'hF0, 8'h20, 8'h01};
        run_load(6'd50, 7'd3, 0, 99);
        chk("checksum", {24'd0, lb.checksum_o}, 32'h11);
        run_load(6'd0, 7'd0, 0, 99);
        chk("checksum_clr", {24'd0, lb.checksum_o}, 32'h0);
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/matrix_mem_loader.md
MATRIX_MEM_LOADER -- requirements
Module: matrix_mem_loader

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_W, 6, memory address width; memory depth is 2^ADDR_W.
- DATA_W, 8, memory word and stream byte width.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic is on its rising edge.
- rst, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle load request.
- base_addr, in, ADDR_W, first write address, sampled on start.
- length, in, ADDR_W+1, number of words to write (0..2^ADDR_W), sampled on start.
- in_valid, in, 1, stream word valid.
- in_data, in, DATA_W, stream word.
- in_ready, out, 1, loader accepts a word this cycle.
- mem_addr_o, out, ADDR_W, single-port RAM address.
- mem_data_o, out, DATA_W, single-port RAM write data.
- mem_we_o, out, 1, single-port RAM write enable.
- busy_o, out, 1, high in LOAD.
- is_done_o, out, 1, load complete flag.
- count_o, out, ADDR_W+1, number of words written so far.

Function
REQ-003 The FSM SHALL have three states: IDLE, LOAD and DONE.
REQ-004 In IDLE with start=1, the block SHALL latch base_addr and length and clear count.
- length=0: go to DONE.
- otherwise: go to LOAD.
REQ-005 In DONE with start=1, the block SHALL behave exactly as REQ-004 (restart).
REQ-006 While in LOAD, start SHALL be ignored.
REQ-007 in_ready SHALL be 1 only in LOAD and combinationally 0 elsewhere. A transfer occurs on a cycle with in_valid=1 and in_ready=1.
REQ-008 On a transfer, on the next rising edge:
- mem_we_o=1;
- mem_data_o=in_data;
- mem_addr_o=(base+count) mod 2^ADDR_W;
- count increments by 1.
Write latency is 1 cycle.
REQ-009 On cycles without a transfer, mem_we_o SHALL be 0. mem_addr_o and mem_data_o SHALL hold their last values.
REQ-010 Addresses SHALL wrap modulo 2^ADDR_W. Example: base=62, length=4 writes addresses 62, 63, 0, 1.
REQ-011 On the transfer that makes count equal to length, the FSM SHALL move to DONE. in_ready SHALL be 0 on the following cycle, and no further words are accepted.
REQ-012 is_done_o SHALL be 1 in DONE and 0 in IDLE and LOAD.
REQ-013 busy_o SHALL be 1 exactly in LOAD.
REQ-014 count_o SHALL show the registered count. It holds its final value in DONE until the next start.
REQ-015 in_valid=0 gaps of any length SHALL stall the load without losing or duplicating words.

Reset
REQ-016 While rst=0, asynchronously and regardless of clk, the block SHALL force:
- state=IDLE;
- mem_we_o=0, mem_addr_o=0, mem_data_o=0;
- count_o=0, busy_o=0, is_done_o=0, in_ready=0.
REQ-017 Reset asserted mid-LOAD SHALL abort the load with no further writes. After rst returns to 1, the block SHALL wait in IDLE for start.

Configuration
REQ-018 When macro LOADER_CHECKSUM_EN is defined, the block SHALL add output checksum_o, width DATA_W.
- checksum_o is the modulo-2^DATA_W sum of all words written since the last start.
- It is cleared by start and by reset, and updates in the same cycle as mem_we_o.
- Without LOADER_CHECKSUM_EN, neither the port nor its logic SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- base=0, length=8, in_valid held high, data 1..8 -> writes at addr 0..7 on 8 consecutive cycles; is_done_o=1 the cycle after the 8th write; count_o=8.
- base=62, length=4, data A0..A3 -> addr 62, 63, 0, 1; RAM readback matches.
- length=5 with in_valid toggling 1,0,0,1,... -> exactly 5 writes, no duplicates; in_ready=0 after the 5th transfer.
- length=0 -> DONE the cycle after start; zero writes; count_o=0.
- rst=0 after 3 of 6 writes -> mem_we_o=0 immediately and all outputs 0; a new start with base=10, length=2 then writes addr 10 and 11 correctly.
- With LOADER_CHECKSUM_EN defined, data F0, 20, 01 -> checksum_o=11 (hex) at DONE; a start in DONE clears it to 0.
